// File: rtl/aux_winner_detector_pkg.sv
// aux_winner_detector_pkg: shared types and constants for the aux winner detector.
//   state_t   compare pipeline states (IDLE -> COMPARE -> UPDATE)
//   NUM_AUX   number of aux channels
//   IDX_W     width of a channel index
//   CH0..CH3  channel index constants
package aux_winner_detector_pkg;
    localparam int NUM_AUX = 4;
    localparam int IDX_W = 2;
    localparam logic [IDX_W-1:0] CH0 = 2'd0;
    localparam logic [IDX_W-1:0] CH1 = 2'd1;
    localparam logic [IDX_W-1:0] CH2 = 2'd2;
    localparam logic [IDX_W-1:0] CH3 = 2'd3;
    typedef enum logic [1:0] {IDLE, COMPARE, UPDATE} state_t;
endpackage

// File: rtl/aux_winner_detector_if.sv
// aux_winner_detector_if: sample input bus and result outputs of the winner detector.
//   en, sample_valid, aux0..aux3                     driven by the sample source (master)
//   network_output, winner_valid, result_valid,
//   winner_changed, avg_aux0..avg_aux3, overrun      driven by the detector (slave)
interface aux_winner_detector_if #(parameter int DATA_W = 12);
    logic              en;
    logic              sample_valid;
    logic [DATA_W-1:0] aux0, aux1, aux2, aux3;
    logic [1:0]        network_output;
    logic              winner_valid;
    logic              result_valid;
    logic              winner_changed;
    logic [DATA_W-1:0] avg_aux0, avg_aux1, avg_aux2, avg_aux3;
    logic              overrun;
    modport master (
        output en, sample_valid, aux0, aux1, aux2, aux3,
        input  network_output, winner_valid, result_valid, winner_changed,
               avg_aux0, avg_aux1, avg_aux2, avg_aux3, overrun
    );
    modport slave (
        input  en, sample_valid, aux0, aux1, aux2, aux3,
        output network_output, winner_valid, result_valid, winner_changed,
               avg_aux0, avg_aux1, avg_aux2, avg_aux3, overrun
    );
endinterface

// File: rtl/aux_winner_detector_avg.sv
// aux_winner_detector_avg: one channel's window accumulator and truncating averager.
//   clk, rst      clock, synchronous active-high reset
//   clr           discard the partial window sum (average is held)
//   sample_valid  add din to the window
//   last          this sample completes the window (window count lives in the top)
//   din           channel measurement
//   avg           average of the last completed window
module aux_winner_detector_avg #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              sample_valid,
    input  logic              last,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] avg
);
    localparam int SW = DATA_W + AVG_LOG2;
    logic [SW-1:0] sum, total;
    // Sum is wide enough for 2^AVG_LOG2 full-scale samples, so it never wraps.
    assign total = sum + SW'(din);
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
            avg <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (sample_valid) begin
            sum <= last ? '0 : total;
            if (last) avg <= DATA_W'(total >> AVG_LOG2);
        end
    end
endmodule

// File: rtl/aux_winner_detector.sv
// aux_winner_detector: picks the strongest of four averaged aux channels with hysteresis
// and N-window stability qualification.
//   clk, rst  clock, synchronous active-high reset
//   bus       aux_winner_detector_if.slave: en, sample_valid, aux0..3 in;
//             network_output, winner_valid, result_valid, winner_changed,
//             avg_aux0..3, overrun out
module aux_winner_detector
    import aux_winner_detector_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int AVG_LOG2   = 2,
    parameter int HYST       = 16,
    parameter int STABLE_CNT = 3,
    parameter int MIN_LEVEL  = 256
) (
    input  logic clk,
    input  logic rst,
    aux_winner_detector_if.slave bus
);
    localparam int CW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
    logic [DATA_W-1:0] aux [NUM_AUX];
    logic [DATA_W-1:0] avg [NUM_AUX];
    logic [CW-1:0]     win_cnt;
    logic              last, win_done;
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cand_q, pending_q, pending_d, net_q, net_d, max_idx;
    logic [DATA_W-1:0] max_val;
    logic [3:0]        stab_q, stab_d, cnt;
    logic              below_q, wv_q, wv_d, rv_q, chg_q, chg_d, ovr_q, qualify, hyst_ok;
    assign aux[0] = bus.aux0;
    assign aux[1] = bus.aux1;
    assign aux[2] = bus.aux2;
    assign aux[3] = bus.aux3;
    // With AVG_LOG2=0 every strobe closes a window; win_cnt then stays at 0.
    assign last = (win_cnt == CW'((1 << AVG_LOG2) - 1));
    assign win_done = bus.sample_valid && last;
    for (genvar i = 0; i < NUM_AUX; i++) begin : g_ch
        aux_winner_detector_avg #(.DATA_W(DATA_W), .AVG_LOG2(AVG_LOG2)) u_avg (
            .clk(clk), .rst(rst), .clr(!bus.en), .sample_valid(bus.sample_valid),
            .last(last), .din(aux[i]), .avg(avg[i])
        );
    end
    // Argmax with strict compare so ties resolve to the lowest index.
    always_comb begin
        max_idx = CH0;
        max_val = avg[0];
        for (int k = 1; k < NUM_AUX; k++) begin
            if (avg[k] > max_val) begin
                max_val = avg[k];
                max_idx = IDX_W'(k);
            end
        end
    end
    // One extra bit keeps winner+HYST from wrapping near full scale.
    assign hyst_ok = {1'b0, avg[cand_q]} >= {1'b0, avg[net_q]} + (DATA_W+1)'(HYST);
    always_comb begin
        state_d   = state_q == IDLE ? (win_done ? COMPARE : IDLE) : state_q == COMPARE ? UPDATE : IDLE;
        pending_d = pending_q;
        stab_d    = stab_q;
        net_d     = net_q;
        wv_d      = wv_q;
        chg_d     = 1'b0;
        qualify   = 1'b0;
        cnt       = '0;
        if (state_q == UPDATE) begin
            qualify = !below_q && (!wv_q || (cand_q != net_q && hyst_ok));
            cnt     = cand_q == pending_q ? stab_q + 4'd1 : 4'd1;
            pending_d = qualify ? cand_q : '0;
            stab_d    = qualify ? cnt : '0;
            if (qualify && cnt == 4'(STABLE_CNT)) begin
                net_d  = cand_q;
                wv_d   = 1'b1;
                stab_d = '0;
                chg_d  = !wv_q || cand_q != net_q;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt   <= '0;
            state_q   <= IDLE;
            cand_q    <= '0;
            below_q   <= 1'b0;
            pending_q <= '0;
            stab_q    <= '0;
            net_q     <= '0;
            wv_q      <= 1'b0;
            rv_q      <= 1'b0;
            chg_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else if (!bus.en) begin
            win_cnt   <= '0;
            state_q   <= IDLE;
            pending_q <= '0;
            stab_q    <= '0;
            rv_q      <= 1'b0;
            chg_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            if (bus.sample_valid) win_cnt <= last ? '0 : win_cnt + CW'(1);
            state_q   <= state_d;
            if (state_q == COMPARE) begin
                cand_q  <= max_idx;
                below_q <= {1'b0, max_val} < (DATA_W+1)'(MIN_LEVEL);
            end
            pending_q <= pending_d;
            stab_q    <= stab_d;
            net_q     <= net_d;
            wv_q      <= wv_d;
            rv_q      <= state_q == UPDATE;
            chg_q     <= chg_d;
            // A window landing while a compare is in flight is averaged but not judged.
            ovr_q     <= ovr_q | (win_done && state_q != IDLE);
        end
    end
    assign bus.network_output = net_q;
    assign bus.winner_valid   = wv_q;
    assign bus.result_valid   = rv_q;
    assign bus.winner_changed = chg_q;
    assign bus.avg_aux0       = avg[0];
    assign bus.avg_aux1       = avg[1];
    assign bus.avg_aux2       = avg[2];
    assign bus.avg_aux3       = avg[3];
    assign bus.overrun        = ovr_q;
endmodule

// File: tb/tb_aux_winner_detector.sv
// tb_aux_winner_detector: scoreboard bench for aux_winner_detector (windowed and
// per-sample configurations).
module tb_aux_winner_detector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aux_winner_detector_if #(.DATA_W(12)) i1 ();
    aux_winner_detector_if #(.DATA_W(12)) i2 ();

    aux_winner_detector #(.DATA_W(12), .AVG_LOG2(2), .HYST(16), .STABLE_CNT(3), .MIN_LEVEL(256))
        d1 (.clk(clk), .rst(rst), .bus(i1));
    aux_winner_detector #(.DATA_W(12), .AVG_LOG2(0), .HYST(16), .STABLE_CNT(3), .MIN_LEVEL(256))
        d2 (.clk(clk), .rst(rst), .bus(i2));

    int total = 0;
    int bad = 0;
    int n_res = 0;
    logic [51:0] sb[$];

    task automatic check(input string name, input logic [51:0] act, input logic [51:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [51:0] rec();
        return {i1.network_output, i1.winner_valid, i1.winner_changed,
                i1.avg_aux0, i1.avg_aux1, i1.avg_aux2, i1.avg_aux3};
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (i1.winner_changed && !i1.result_valid) begin
                total++;
                bad++;
                $display("FAIL chg_alone: winner_changed=1 without result_valid");
            end
            if (i1.result_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got %h expected none", rec());
                end else begin
                    check($sformatf("result%0d", n_res), rec(), sb.pop_front());
                    n_res++;
                end
            end
        end
    endtask

    task automatic strobe(input logic [11:0] a0, a1, a2, a3);
        @(negedge clk);
        i1.sample_valid = 1'b1;
        i1.aux0 = a0; i1.aux1 = a1; i1.aux2 = a2; i1.aux3 = a3;
        @(negedge clk);
        i1.sample_valid = 1'b0;
    endtask

    task automatic window(input logic [11:0] a0, a1, a2, a3,
                          input logic [1:0] net, input logic wv, input logic chg);
        sb.push_back({net, wv, chg, a0, a1, a2, a3});
        repeat (4) strobe(a0, a1, a2, a3);
        for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got no result_valid expected %h", sb[0]);
            sb.delete();
        end
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i1.en = 1'b1; i1.sample_valid = 1'b0;
        i1.aux0 = '0; i1.aux1 = '0; i1.aux2 = '0; i1.aux3 = '0;
        i2.en = 1'b1; i2.sample_valid = 1'b0;
        i2.aux0 = '0; i2.aux1 = '0; i2.aux2 = '0; i2.aux3 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        fork monitor(); join_none
        // reset mid-window: partial FFF samples must not leak into the next window
        strobe(12'hFFF, 12'h0, 12'h0, 12'h0);
        strobe(12'hFFF, 12'h0, 12'h0, 12'h0);
        pulse_rst();
        check("reset_outputs", rec(), 52'h0);
        check("reset_flags", {50'h0, i1.result_valid, i1.overrun}, 52'h0);
        // first winner: channel 2 after three windows
        window(12'h100, 12'h100, 12'h800, 12'h100, 2'd0, 1'b0, 1'b0);
        window(12'h100, 12'h100, 12'h800, 12'h100, 2'd0, 1'b0, 1'b0);
        window(12'h100, 12'h100, 12'h800, 12'h100, 2'd2, 1'b1, 1'b1);
        // challenger one LSB short of hysteresis never takes over
        for (int w = 0; w < 5; w++) window(12'h100, 12'h80F, 12'h800, 12'h100, 2'd2, 1'b1, 1'b0);
        // challenger exactly at hysteresis wins on the third window
        window(12'h100, 12'h810, 12'h800, 12'h100, 2'd2, 1'b1, 1'b0);
        window(12'h100, 12'h810, 12'h800, 12'h100, 2'd2, 1'b1, 1'b0);
        window(12'h100, 12'h810, 12'h800, 12'h100, 2'd1, 1'b1, 1'b1);
        // below MIN_LEVEL holds the winner and restarts stability counting
        window(12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF, 2'd1, 1'b1, 1'b0);
        window(12'h100, 12'h100, 12'h100, 12'h900, 2'd1, 1'b1, 1'b0);
        window(12'h0FF, 12'h0FF, 12'h0FF, 12'h0FF, 2'd1, 1'b1, 1'b0);
        window(12'h100, 12'h100, 12'h100, 12'h900, 2'd1, 1'b1, 1'b0);
        window(12'h100, 12'h100, 12'h100, 12'h900, 2'd1, 1'b1, 1'b0);
        window(12'h100, 12'h100, 12'h100, 12'h900, 2'd3, 1'b1, 1'b1);
        // tie between channels 0 and 3 resolves to 0; first qualification pulses
        pulse_rst();
        check("reset2_outputs", rec(), 52'h0);
        window(12'h500, 12'h000, 12'h000, 12'h500, 2'd0, 1'b0, 1'b0);
        window(12'h500, 12'h000, 12'h000, 12'h500, 2'd0, 1'b0, 1'b0);
        window(12'h500, 12'h000, 12'h000, 12'h500, 2'd0, 1'b1, 1'b1);
        // en low holds winner/averages and discards a partial window
        strobe(12'hFFF, 12'hFFF, 12'h0, 12'h0);
        strobe(12'hFFF, 12'hFFF, 12'h0, 12'h0);
        @(negedge clk);
        i1.en = 1'b0;
        @(negedge clk);
        check("en_low_hold", rec(), {2'd0, 1'b1, 1'b0, 12'h500, 12'h000, 12'h000, 12'h500});
        check("en_low_rv", {51'h0, i1.result_valid}, 52'h0);
        i1.en = 1'b1;
        window(12'h500, 12'h000, 12'h000, 12'h500, 2'd0, 1'b1, 1'b0);
        check("d1_no_overrun", {51'h0, i1.overrun}, 52'h0);
        // per-sample windows back to back raise a sticky overrun
        @(negedge clk);
        i2.sample_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            i2.aux0 = 12'(k * 16);
            @(negedge clk);
        end
        i2.sample_valid = 1'b0;
        check("overrun_set", {51'h0, i2.overrun}, 52'h1);
        check("d2_avg", {40'h0, i2.avg_aux0}, 52'h040);
        repeat (5) @(negedge clk);
        check("overrun_sticky", {51'h0, i2.overrun}, 52'h1);
        i2.en = 1'b0;
        @(negedge clk);
        check("overrun_clear", {51'h0, i2.overrun}, 52'h0);
        i2.en = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_empty", 52'(sb.size()), 52'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
